// File: rtl/shift_defs.sv
// Shared definitions for the multi-cycle shift/rotate stage: operation codes,
// FSM state encoding and default datapath geometry.
package shift_defs;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEP  = 1;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP bits. Only constant shift
// distances up to STEP are built, so the mux stays bounded to STEP+1 inputs.
module shift_step
    import shift_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP,
    parameter int NW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [2:0]       op_i,
    input  logic [NW-1:0]    n_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] value_o
);

    // Select the pre-shifted candidate matching the requested distance; n=0 passes through.
    always_comb begin
        value_o = value_i;
        for (int k = 1; k <= STEP; k++) begin
            if (n_i == NW'(k)) begin
                case (op_i)
                    OP_SHR:  value_o = value_i >> k;
                    OP_SHRA: value_o = (value_i >> k) |
                                       (sign_i ? ~({WIDTH{1'b1}} >> k) : '0);
                    OP_SHL:  value_o = value_i << k;
                    OP_ROR:  value_o = (value_i >> k) | (value_i << (WIDTH - k));
                    OP_ROL:  value_o = (value_i << k) | (value_i >> (WIDTH - k));
                    default: value_o = value_i;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift/rotate unit: latches operand and amount on start, shifts
// up to STEP bits per clock and signals completion with a one-cycle done pulse.
module shift_seq_unit
    import shift_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int NW = $clog2(STEP) + 1;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       op_q;
    logic             sign_q;
    logic             busy_q;
    logic             done_q;

    logic [CW-1:0]    loadCount;
    logic [NW-1:0]    stepN;
    logic [WIDTH-1:0] result_d;

    // Starting count: linear shifts saturate at WIDTH, rotates wrap modulo WIDTH, illegal ops do nothing.
    always_comb begin
        loadCount = '0;
        case (op)
            OP_SHR, OP_SHRA, OP_SHL:
                loadCount = (b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : b[CW-1:0];
            OP_ROR, OP_ROL:
                loadCount = {1'b0, b[CW-2:0]};
            default:
                loadCount = '0;
        endcase
    end

    // Distance for this cycle is the smaller of STEP and what is left to shift.
    always_comb begin
        stepN = (count_q >= CW'(STEP)) ? NW'(STEP) : count_q[NW-1:0];
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .NW    (NW)
    ) u_step (
        .value_i (result_q),
        .op_i    (op_q),
        .n_i     (stepN),
        .sign_i  (sign_q),
        .value_o (result_d)
    );

    // Control FSM with registered busy/done; result register doubles as the shift accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            result_q <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        result_q <= a;
                        op_q     <= op;
                        sign_q   <= a[WIDTH-1];
                        count_q  <= loadCount;
                        busy_q   <= 1'b1;
                        if (loadCount != '0) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= result_d;
                    count_q  <= count_q - CW'(stepN);
                    if (count_q == CW'(stepN)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
